// File: rtl/seg7_reader.sv
// Seven-segment bus monitor: recovers the hex digit shown on each of six displays
// after synchronising and debouncing every segment bus.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] disp0,
    input  logic [6:0] disp1,
    input  logic [6:0] disp2,
    input  logic [6:0] disp3,
    input  logic [6:0] disp4,
    input  logic [6:0] disp5,
    output logic [3:0] hexOut0,
    output logic [3:0] hexOut1,
    output logic [3:0] hexOut2,
    output logic [3:0] hexOut3,
    output logic [3:0] hexOut4,
    output logic [3:0] hexOut5,
    output logic [5:0] digitValid,
    output logic       frameStrobe,
    output logic [7:0] errCount
);

    localparam int unsigned NDIG = 6;
    localparam int unsigned SW   = 7;
    localparam int unsigned HW   = 4;
    localparam int unsigned EW   = 8;
    localparam int unsigned CW   = (STABLE_CYCLES + 1 > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

    localparam logic [SW-1:0] SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [EW-1:0] ERR_MAX  = 8'hFF;

    // Active-high glyph to {legal, value}; unknown patterns return legal = 0
    function automatic logic [HW:0] decode(input logic [SW-1:0] seg);
        logic [HW:0] r;
        r = '0;
        case (seg)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [SW-1:0] disp_a    [NDIG];
    logic [SW-1:0] sync1     [NDIG];
    logic [SW-1:0] s         [NDIG];
    logic [SW-1:0] p         [NDIG];
    logic [SW-1:0] committed [NDIG];
    logic [CW-1:0] cnt       [NDIG];
    logic [HW-1:0] hex_q     [NDIG];
    logic [HW:0]   dec_c     [NDIG];
    logic [NDIG-1:0] commit_c;
    logic [NDIG-1:0] err_c;

    assign disp_a[0] = disp0;
    assign disp_a[1] = disp1;
    assign disp_a[2] = disp2;
    assign disp_a[3] = disp3;
    assign disp_a[4] = disp4;
    assign disp_a[5] = disp5;

    assign hexOut0 = hex_q[0];
    assign hexOut1 = hex_q[1];
    assign hexOut2 = hex_q[2];
    assign hexOut3 = hex_q[3];
    assign hexOut4 = hex_q[4];
    assign hexOut5 = hex_q[5];

    // Commit detection and decode of the synchronised pattern
    always_comb begin
        commit_c = '0;
        err_c    = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            dec_c[i]    = decode(ACTIVE_LOW ? ~s[i] : s[i]);
            commit_c[i] = (s[i] == p[i]) && (cnt[i] == CNT_LAST) && (s[i] != committed[i]);
            err_c[i]    = commit_c[i] && !dec_c[i][HW] && (s[i] != SEG_OFF);
        end
    end

    // Synchronisers, debounce counters, committed state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                sync1[i]     <= SEG_OFF;
                s[i]         <= SEG_OFF;
                p[i]         <= SEG_OFF;
                committed[i] <= SEG_OFF;
                cnt[i]       <= '0;
                hex_q[i]     <= '0;
            end
            digitValid  <= '0;
            frameStrobe <= 1'b0;
            errCount    <= '0;
        end else begin
            for (int i = 0; i < int'(NDIG); i++) begin
                sync1[i] <= disp_a[i];
                s[i]     <= sync1[i];
                p[i]     <= s[i];
                if (s[i] != p[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
                if (commit_c[i]) begin
                    committed[i]  <= s[i];
                    digitValid[i] <= dec_c[i][HW];
                    if (dec_c[i][HW]) begin
                        hex_q[i] <= dec_c[i][HW-1:0];
                    end
                end
            end
            frameStrobe <= |commit_c;
            if ((|err_c) && (errCount != ERR_MAX)) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed-vector bench for seg7_reader with STABLE_CYCLES=4, ACTIVE_LOW=1.
module tb_seg7_reader;

    logic       clk;
    logic       rst;
    logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic [3:0] hexOut0, hexOut1, hexOut2, hexOut3, hexOut4, hexOut5;
    logic [5:0] digitValid;
    logic       frameStrobe;
    logic [7:0] errCount;

    int n_cmp;
    int n_err;
    int strobes;

    // Active-high glyphs 0..F; the bench drives their inverses
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst),
        .disp0(disp0), .disp1(disp1), .disp2(disp2),
        .disp3(disp3), .disp4(disp4), .disp5(disp5),
        .hexOut0(hexOut0), .hexOut1(hexOut1), .hexOut2(hexOut2),
        .hexOut3(hexOut3), .hexOut4(hexOut4), .hexOut5(hexOut5),
        .digitValid(digitValid), .frameStrobe(frameStrobe), .errCount(errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, sample 1 ns later and tally strobes
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (frameStrobe === 1'b1) strobes++;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; strobes = 0;
        rst = 1'b0;
        disp0 = 7'h7F; disp1 = 7'h7F; disp2 = 7'h7F;
        disp3 = 7'h7F; disp4 = 7'h7F; disp5 = 7'h7F;
        #22;
        chk("rst_valid", 32'(digitValid), 32'h0);
        chk("rst_err", 32'(errCount), 32'h0);
        chk("rst_hex0", 32'(hexOut0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: idle at the off pattern
        step(50);
        chk("idle_strobes", 32'(strobes), 32'd0);
        chk("idle_valid", 32'(digitValid), 32'h0);
        chk("idle_err", 32'(errCount), 32'h0);

        // 2: glyph 2 on disp2, commit lands on edge 7
        strobes = 0;
        disp2 = 7'h24;
        step(6);
        chk("lat_e6_valid", 32'(digitValid), 32'h0);
        chk("lat_e6_strobe", 32'(frameStrobe), 32'h0);
        step(1);
        chk("lat_e7_hex2", 32'(hexOut2), 32'h2);
        chk("lat_e7_valid", 32'(digitValid), 32'h04);
        chk("lat_e7_strobe", 32'(frameStrobe), 32'h1);
        chk("lat_e7_hex0", 32'(hexOut0), 32'h0);
        step(1);
        chk("lat_e8_strobe", 32'(frameStrobe), 32'h0);
        step(10);
        chk("lat_strobes", 32'(strobes), 32'd1);

        // 3: sweep all glyphs on disp0
        strobes = 0;
        for (int g = 0; g < 16; g++) begin
            disp0 = ~glyph[g];
            step(20);
            chk($sformatf("sweep_hex0_%0d", g), 32'(hexOut0), 32'(g));
            chk($sformatf("sweep_v0_%0d", g), 32'(digitValid[0]), 32'h1);
        end
        chk("sweep_strobes", 32'(strobes), 32'd16);
        chk("sweep_err", 32'(errCount), 32'h0);

        // 4: short glitch on disp1 is ignored, long hold commits
        disp1 = 7'h40;
        step(20);
        chk("gl_hex1_init", 32'(hexOut1), 32'h0);
        strobes = 0;
        disp1 = 7'h79;
        step(3);
        disp1 = 7'h40;
        step(15);
        chk("gl_strobes", 32'(strobes), 32'd0);
        chk("gl_hex1", 32'(hexOut1), 32'h0);
        chk("gl_valid1", 32'(digitValid[1]), 32'h1);
        disp1 = 7'h79;
        step(10);
        chk("gl_hex1_long", 32'(hexOut1), 32'h1);
        chk("gl_strobes_long", 32'(strobes), 32'd1);

        // 5: simultaneous illegal commits, then saturation
        strobes = 0;
        disp3 = 7'h36;
        disp4 = 7'h36;
        step(10);
        chk("ill_strobes", 32'(strobes), 32'd1);
        chk("ill_err", 32'(errCount), 32'd1);
        chk("ill_valid", 32'(digitValid), 32'h07);
        chk("ill_hex3", 32'(hexOut3), 32'h0);
        chk("ill_hex4", 32'(hexOut4), 32'h0);
        for (int t = 1; t <= 300; t++) begin
            disp3 = (t % 2 == 1) ? 7'h76 : 7'h36;
            step(10);
            if (t == 253) chk("sat_254", 32'(errCount), 32'd254);
            if (t == 254) chk("sat_255", 32'(errCount), 32'd255);
        end
        chk("sat_hold", 32'(errCount), 32'd255);
        chk("sat_valid", 32'(digitValid), 32'h07);

        // 6: async reset mid-debounce on disp5, then recommit of all held patterns
        disp5 = 7'h40;
        step(3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(digitValid), 32'h0);
        chk("ar_err", 32'(errCount), 32'h0);
        chk("ar_strobe", 32'(frameStrobe), 32'h0);
        chk("ar_hex0", 32'(hexOut0), 32'h0);
        chk("ar_hex1", 32'(hexOut1), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        strobes = 0;
        step(6);
        chk("ar_e6_valid", 32'(digitValid), 32'h0);
        chk("ar_e6_strobe", 32'(frameStrobe), 32'h0);
        step(1);
        chk("ar_e7_valid", 32'(digitValid), 32'h27);
        chk("ar_e7_hex5", 32'(hexOut5), 32'h0);
        chk("ar_e7_hex0", 32'(hexOut0), 32'hF);
        chk("ar_e7_hex2", 32'(hexOut2), 32'h2);
        chk("ar_e7_err", 32'(errCount), 32'd1);
        chk("ar_e7_strobe", 32'(frameStrobe), 32'h1);
        step(5);
        chk("ar_strobes", 32'(strobes), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Inverse of the hex-to-seven-segment path: monitors six 7-segment display buses and recovers the 4-bit hex digit shown on each.
- Each digit is synchronised, debounced (pattern must be stable for STABLE_CYCLES clocks), then decoded.
- Reports per-digit valid flags, a commit strobe and a saturating illegal-pattern counter.
- Used as an on-chip display monitor/loopback checker and for reading segment buses from external boards.

Parameters:
- STABLE_CYCLES, 4, consecutive clocks a synchronised pattern must be unchanged before commit; legal range 1..255.
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous reset, active-low
- disp0..disp5  input  7 each  segment buses; bit0=a, bit1=b … bit6=g; may be asynchronous to clk
- hexOut0..hexOut5  output  4 each  last legally decoded digit per display
- digitValid  output  6  bit i = 1 when hexOut{i} reflects a legal glyph currently committed on disp{i}
- frameStrobe  output  1  one-cycle pulse on any digit commit
- errCount  output  8  number of cycles in which an illegal pattern was committed; saturates at 255

Behaviour:
- Reset (rst=0, async) clears all outputs and committed patterns to the all-segments-off state:
  - hexOut* = 0, digitValid = 0, frameStrobe = 0, errCount = 0.
  - Synchroniser and previous-sample registers load the off pattern: 7'h7F if ACTIVE_LOW, else 7'h00.
  - Stability counters = 0.
- Per-digit pipeline:
  - Two-flop synchroniser produces s; previous-sample register p <= s.
  - Counter cnt (width clog2(STABLE_CYCLES+1)): cnt <= 0 if s != p; else cnt <= cnt+1, saturating at STABLE_CYCLES.
  - Commit fires when s == p, cnt == STABLE_CYCLES-1, and s != committed pattern. Committed pattern <= s.
- Decode on commit (active-high glyphs; invert first when ACTIVE_LOW):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Legal glyph: hexOut{i} <= value, digitValid[i] <= 1.
  - All segments off (blank): digitValid[i] <= 0, hexOut{i} held, not an error.
  - Any other pattern: digitValid[i] <= 0, hexOut{i} held, error.
- Latency: hexOut/digitValid/frameStrobe update on edge STABLE_CYCLES+3, counting the first clk edge that samples the new pin value as edge 1.
- Glitches:
  - A pattern held for fewer than STABLE_CYCLES+1 synchronised cycles is never committed.
  - A return to the already-committed pattern produces no commit and no strobe.
- Simultaneous events:
  - Commits on several digits in one cycle → a single frameStrobe pulse.
  - errCount increments by 1 per cycle containing ≥1 illegal commit, regardless of how many digits.
- frameStrobe is registered, high exactly one cycle per commit cycle. Back-to-back commit cycles give back-to-back pulses.
- errCount holds at 255; it does not wrap.
- Reset asserted mid-debounce aborts all pending commits. After release, counting restarts from the off pattern.

Test Plan:
1. Reset then disp0..5 held at off pattern (7F, ACTIVE_LOW=1) for 50 cycles → digitValid=0, frameStrobe never pulses, errCount=0.
2. STABLE_CYCLES=4, ACTIVE_LOW=1: disp2 set to 7'h24 (glyph 2 inverted) → on edge 7 hexOut2=2, digitValid[2]=1, frameStrobe high for exactly one cycle; other digits unchanged.
3. disp0 steps through all 16 inverted glyphs, each held 20 cycles → hexOut0 follows 0..F, digitValid[0] stays 1, 16 strobes, errCount=0.
4. Glitch: committed disp1=7'h40 (0); drive 7'h79 (1) for 3 cycles, then back to 40 → no strobe, hexOut1 stays 0; hold 7'h79 for 10 cycles → commit to 1.
5. Illegal 7'h00 (all lit is glyph 8, so use active-high 0x49 inverted = 7'h36) on disp3 and disp4 in the same cycle → one strobe, errCount +1, digitValid[3]=digitValid[4]=0, hexOut3/4 held; repeat 300 distinct illegal toggles → errCount saturates at 255.
6. Assert rst mid-debounce (cycle 3 after a disp5 change) → all outputs zero immediately, asynchronously; after release, the held pattern commits STABLE_CYCLES+3 edges later.
